i2c_master_arbiter: RTL

I2C_MASTER_ARBITER -- requirements
Module: i2c_master_arbiter

---
 rtl/i2c_arb_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/i2c_master_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C master arbiter: FSM encoding, field
// widths and the bus-free guard length derived from the clock and SCL rates.
package i2c_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_XFER  = 2'd2,
        ST_GUARD = 2'd3
    } arb_state_e;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    // Two SCL periods cover the STOP condition plus the minimum bus-free time.
    function automatic int guard_cycles(input int clock_freq, input int scl_freq);
        longint prod;
        prod = 64'sd2 * longint'(clock_freq);
        return int'(prod / longint'(scl_freq));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: the search starts one position after the
// previous winner and wraps, returning a one-hot grant and a valid flag.
module rr_arbiter #(
    parameter int G_NB_REQ = 2,
    parameter int IDX_W    = 1
) (
    input  logic [G_NB_REQ-1:0] req,
    input  logic [IDX_W-1:0]    last,
    output logic [G_NB_REQ-1:0] grant,
    output logic                valid
);

    logic hit;

    // Walk offsets 1..N from the last winner; the first asserted request wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        hit   = 1'b0;
        for (int i = 1; i <= G_NB_REQ; i++) begin
            for (int k = 0; k < G_NB_REQ; k++) begin
                hit      = (k == ((int'(last) + i) % G_NB_REQ));
                grant[k] = grant[k] | (hit & req[k] & ~valid);
                valid    = valid | (hit & req[k]);
            end
        end
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one i2c_master between G_NB_REQ requesters: round-robin grant, one
// transaction at a time, byte counting, watchdog and a bus-free guard period.
module i2c_master_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int G_NB_REQ      = 2,
    parameter int G_CLOCK_FREQ  = 50_000_000,
    parameter int G_SCL_FREQ    = 400_000,
    parameter int G_TIMEOUT_CYC = 1_000_000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [G_NB_REQ-1:0]          i_req,
    input  logic [G_NB_REQ-1:0]          i_rw,
    input  logic [ADDR_W*G_NB_REQ-1:0]   i_chip_addr,
    input  logic [DATA_W*G_NB_REQ-1:0]   i_nb_data,
    input  logic [DATA_W*G_NB_REQ-1:0]   i_wdata,
    output logic [G_NB_REQ-1:0]          o_grant,
    output logic [G_NB_REQ-1:0]          o_done,
    output logic [G_NB_REQ-1:0]          o_error,
    output logic [G_NB_REQ-1:0]          o_rdata_valid,
    output logic [G_NB_REQ-1:0]          o_wdata_req,
    output logic [DATA_W-1:0]            o_rdata,
    output logic                         o_start,
    output logic                         o_rw,
    output logic [ADDR_W-1:0]            o_chip_addr,
    output logic [DATA_W-1:0]            o_nb_data,
    output logic [DATA_W-1:0]            o_wdata,
    input  logic [DATA_W-1:0]            i_rdata,
    input  logic                         i_rdata_valid,
    input  logic                         i_next_wdata_rdy,
    input  logic                         i_sack_error
);

    localparam int IDX_W     = $clog2(G_NB_REQ);
    localparam int GUARD_CYC = guard_cycles(G_CLOCK_FREQ, G_SCL_FREQ);
    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(G_NB_REQ - 1);
    localparam logic [31:0]      GUARD_M1  = 32'(GUARD_CYC - 1);
    localparam logic [31:0]      TMO_M1    = 32'(G_TIMEOUT_CYC - 1);

    arb_state_e             state_r, state_s;
    logic [IDX_W-1:0]       last_r, gnt_idx_r, win_idx_s;
    logic [G_NB_REQ-1:0]    win_oh_s;
    logic                   win_valid_s;
    logic                   win_rw_s;
    logic [ADDR_W-1:0]      win_addr_s;
    logic [CNT_W-1:0]       win_nb_s;

    logic                   rw_r, err_r;
    logic [ADDR_W-1:0]      addr_r;
    logic [CNT_W-1:0]       nb_r, byte_cnt_r;
    logic [31:0]            wd_cnt_r, guard_cnt_r;

    logic                   byte_evt_s, last_byte_s, timeout_s, guard_end_s;
    logic [G_NB_REQ-1:0]    grant_s, done_s, error_s, rdv_s, wreq_s;
    logic                   start_s;
    logic [G_NB_REQ-1:0]    grant_r, done_r, error_r, rdv_r, wreq_r;
    logic                   start_r;
    logic [DATA_W-1:0]      rdata_r, wdata_s;

    rr_arbiter #(
        .G_NB_REQ (G_NB_REQ),
        .IDX_W    (IDX_W)
    ) u_rr (
        .req   (i_req),
        .last  (last_r),
        .grant (win_oh_s),
        .valid (win_valid_s)
    );

    // Winner index and request fields selected by the one-hot grant.
    always_comb begin
        win_idx_s  = '0;
        win_rw_s   = 1'b0;
        win_addr_s = '0;
        win_nb_s   = '0;
        for (int k = 0; k < G_NB_REQ; k++) begin
            win_idx_s  = win_idx_s  | ({IDX_W{win_oh_s[k]}} & IDX_W'(k));
            win_rw_s   = win_rw_s   | (win_oh_s[k] & i_rw[k]);
            win_addr_s = win_addr_s | ({ADDR_W{win_oh_s[k]}} & i_chip_addr[k*ADDR_W +: ADDR_W]);
            win_nb_s   = win_nb_s   | ({CNT_W{win_oh_s[k]}} & i_nb_data[k*DATA_W +: DATA_W]);
        end
    end

    assign byte_evt_s  = rw_r ? i_rdata_valid : i_next_wdata_rdy;
    assign last_byte_s = byte_evt_s && ((byte_cnt_r + 8'd1) == nb_r);
    assign timeout_s   = (wd_cnt_r == TMO_M1);
    // A zero-length request passes through GUARD without waiting.
    assign guard_end_s = (nb_r == 8'd0) || (guard_cnt_r == GUARD_M1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (win_valid_s) begin
                    state_s = (win_nb_s == 8'd0) ? ST_GUARD : ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: state_s = ST_XFER;
            ST_XFER: begin
                if (i_sack_error || last_byte_s || timeout_s) begin
                    state_s = ST_GUARD;
                end else begin
                    state_s = ST_XFER;
                end
            end
            ST_GUARD: begin
                if (guard_end_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_GUARD;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered requester-facing and master-facing strobes.
    always_comb begin
        grant_s = '0;
        done_s  = '0;
        error_s = '0;
        rdv_s   = '0;
        wreq_s  = '0;
        start_s = (state_s == ST_START);
        if (state_s == ST_IDLE) begin
            grant_s = '0;
        end else if (state_r == ST_IDLE) begin
            grant_s = win_oh_s;
        end else begin
            grant_s = grant_r;
        end
        if ((state_r == ST_GUARD) && guard_end_s) begin
            done_s  = grant_r;
            error_s = err_r ? grant_r : '0;
        end else begin
            done_s  = '0;
            error_s = '0;
        end
        if (state_r == ST_XFER) begin
            rdv_s  = i_rdata_valid    ? grant_r : '0;
            wreq_s = i_next_wdata_rdy ? grant_r : '0;
        end else begin
            rdv_s  = '0;
            wreq_s = '0;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_r <= '0;
            done_r  <= '0;
            error_r <= '0;
            rdv_r   <= '0;
            wreq_r  <= '0;
            start_r <= 1'b0;
            rdata_r <= '0;
        end else begin
            grant_r <= grant_s;
            done_r  <= done_s;
            error_r <= error_s;
            rdv_r   <= rdv_s;
            wreq_r  <= wreq_s;
            start_r <= start_s;
            rdata_r <= i_rdata;
        end
    end

    // Transaction context, byte/watchdog/guard counters and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r      <= LAST_RST;
            gnt_idx_r   <= '0;
            rw_r        <= 1'b0;
            addr_r      <= '0;
            nb_r        <= '0;
            byte_cnt_r  <= '0;
            wd_cnt_r    <= '0;
            guard_cnt_r <= '0;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_valid_s) begin
                        gnt_idx_r   <= win_idx_s;
                        rw_r        <= win_rw_s;
                        addr_r      <= win_addr_s;
                        nb_r        <= win_nb_s;
                        byte_cnt_r  <= '0;
                        wd_cnt_r    <= '0;
                        guard_cnt_r <= '0;
                        err_r       <= (win_nb_s == 8'd0);
                    end
                end
                ST_START: begin
                    wd_cnt_r <= wd_cnt_r + 32'd1;
                end
                ST_XFER: begin
                    wd_cnt_r <= wd_cnt_r + 32'd1;
                    if (byte_evt_s) begin
                        byte_cnt_r <= byte_cnt_r + 8'd1;
                    end
                    if (i_sack_error || timeout_s) begin
                        err_r <= 1'b1;
                    end
                end
                ST_GUARD: begin
                    guard_cnt_r <= guard_cnt_r + 32'd1;
                    if (guard_end_s) begin
                        last_r <= gnt_idx_r;
                    end
                end
                default: begin
                    err_r <= err_r;
                end
            endcase
        end
    end

    // Write data follows whichever requester currently holds the grant.
    always_comb begin
        wdata_s = '0;
        for (int k = 0; k < G_NB_REQ; k++) begin
            wdata_s = wdata_s | ({DATA_W{grant_r[k]}} & i_wdata[k*DATA_W +: DATA_W]);
        end
    end

    assign o_grant       = grant_r;
    assign o_done        = done_r;
    assign o_error       = error_r;
    assign o_rdata_valid = rdv_r;
    assign o_wdata_req   = wreq_r;
    assign o_rdata       = rdata_r;
    assign o_start       = start_r;
    assign o_rw          = rw_r;
    assign o_chip_addr   = addr_r;
    assign o_nb_data     = nb_r;
    assign o_wdata       = wdata_s;

endmodule
